// File: rtl/em_sequencer.sv
// em_sequencer: buffers incoming bytes in a small FIFO, writes them one per
// WRITE cycle into an 8-slot memory stage, and sweeps the valid slots back
// out through a valid/ready port on request.
module em_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       start_read,
    output logic       mode,
    output logic [2:0] index,
    output logic [7:0] number,
    input  logic [7:0] result,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic [2:0] out_index,
    input  logic       out_ready,
    output logic       busy,
    output logic [3:0] stored
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = FIFO_DEPTH[PW:0];

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WRITE    = 3'd1;
    localparam logic [2:0] S_RD_SETUP = 3'd2;
    localparam logic [2:0] S_RD_WAIT  = 3'd3;
    localparam logic [2:0] S_RD_OUT   = 3'd4;

    logic [2:0]    state;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [2:0]    wr_ptr;
    logic [2:0]    rd_ptr;
    logic [3:0]    sweep_len;
    logic          pending;

    assign fifo_empty = (count == '0);
    assign in_ready   = RST_N && (count != FULL_CNT);
    assign push       = in_valid && in_ready;
    assign pop        = (state == S_WRITE);
    assign busy       = (state != S_IDLE);

    // Input FIFO: accepts in every state, drained only by WRITE
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                fifo_mem[tail] <= in_data;
                tail           <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer FSM: queued writes drain before any pending sweep is served
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            stored    <= '0;
            sweep_len <= '0;
            pending   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
        end else begin
            if (start_read) begin
                pending <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        state <= S_WRITE;
                    end else if (pending || start_read) begin
                        // Same-cycle start_read is folded in; a request with
                        // nothing stored is dropped rather than kept pending.
                        pending <= 1'b0;
                        if (stored != 4'd0) begin
                            state     <= S_RD_SETUP;
                            rd_ptr    <= '0;
                            sweep_len <= stored;
                        end
                    end
                end
                S_WRITE: begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (stored != 4'd8) begin
                        stored <= stored + 1'b1;
                    end
                    state <= S_IDLE;
                end
                S_RD_SETUP: begin
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    out_data  <= result;
                    out_index <= rd_ptr;
                    out_valid <= 1'b1;
                    state     <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (({1'b0, rd_ptr} + 4'd1) < sweep_len) begin
                            rd_ptr <= rd_ptr + 1'b1;
                            state  <= S_RD_SETUP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory-stage drive: write only in WRITE, read address held through the sweep
    always_comb begin
        mode   = 1'b1;
        index  = '0;
        number = '0;
        case (state)
            S_WRITE: begin
                mode   = 1'b0;
                index  = wr_ptr;
                number = fifo_mem[head];
            end
            S_RD_SETUP, S_RD_WAIT, S_RD_OUT: begin
                index = rd_ptr;
            end
            default: begin
                mode = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_em_sequencer.sv
// tb_em_sequencer: directed, table-driven checks of em_sequencer with a
// one-cycle-latency memory-stage model on the index/result path.
module tb_em_sequencer;

    logic       CLK;
    logic       RST_N;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       start_read;
    logic       mode;
    logic [2:0] index;
    logic [7:0] number;
    logic [7:0] result;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_index;
    logic       out_ready;
    logic       busy;
    logic [3:0] stored;

    int total = 0;
    int bad   = 0;

    em_sequencer #(.FIFO_DEPTH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .start_read(start_read), .mode(mode),
        .index(index), .number(number), .result(result),
        .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .out_ready(out_ready), .busy(busy), .stored(stored)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory stage: registered read, either real contents or 0xA0+index
    logic [7:0] mem [8];
    logic       use_mem = 1'b0;
    always @(posedge CLK) begin
        if (mode == 1'b0) mem[index] <= number;
        result <= use_mem ? mem[index] : (8'hA0 + {5'd0, index});
    end

    // Monitors: record write pulses and accepted read-back beats
    logic [10:0] wr_q[$];
    logic [10:0] rd_q[$];
    int dbl = 0;
    int num_bad = 0;
    logic prev_w = 1'b0;
    always @(negedge CLK) begin
        if (RST_N && mode == 1'b0) begin
            wr_q.push_back({index, number});
            if (prev_w) dbl++;
            prev_w = 1'b1;
        end else begin
            prev_w = 1'b0;
        end
        if (mode && number != 8'd0) num_bad++;
        if (RST_N && out_valid && out_ready) rd_q.push_back({out_index, out_data});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic [2:0] exp_index;
        logic [3:0] exp_stored;
    } wvec_t;

    wvec_t      wv[10];
    logic [7:0] exp_slot[8];
    logic [10:0] exp35[3];
    logic       found;
    logic       done;
    logic       a;
    int         acc;

    initial begin
        // 10-byte write table: slot wraps at 8, stored saturates at 8
        for (int i = 0; i < 10; i++) begin
            wv[i].data       = 8'(i + 1);
            wv[i].exp_index  = 3'(i % 8);
            wv[i].exp_stored = (i + 1 > 8) ? 4'd8 : 4'(i + 1);
        end
        for (int k = 0; k < 10; k++) exp_slot[k % 8] = wv[k].data;
        exp35[0] = {3'd0, 8'h12};
        exp35[1] = {3'd1, 8'h34};
        exp35[2] = {3'd2, 8'h56};

        RST_N = 1'b0; in_valid = 1'b0; in_data = '0; start_read = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_in_ready", in_ready, 0);
        check("rst_mode", mode, 1);
        check("rst_index", index, 0);
        check("rst_number", number, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_stored", stored, 0);
        check("rst_busy", busy, 0);
        RST_N = 1'b1;
        #1 check("post_rst_in_ready", in_ready, 1);

        // start_read with nothing stored is ignored
        start_read = 1'b1;
        @(posedge CLK); #1 start_read = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            check("empty_read_ignored", busy, 0);
        end

        // Three back-to-back pushes
        wr_q.delete();
        in_valid = 1'b1; in_data = 8'h12;
        @(posedge CLK); #1 in_data = 8'h34;
        @(posedge CLK); #1 in_data = 8'h56;
        @(posedge CLK); #1 in_valid = 1'b0;
        repeat (12) @(negedge CLK);
        check("b2b_count", wr_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("b2b_write", (i < wr_q.size()) ? wr_q[i] : 11'h7FF, exp35[i]);
        check("b2b_stored", stored, 3);
        check("b2b_no_sweep", busy, 0);

        // Hand sweep: 2-edge latency and 5-cycle backpressure on slot 0
        start_read = 1'b1;
        @(posedge CLK); #1 start_read = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge CLK);
            check("setup_index", index, s);
            check("setup_mode", mode, 1);
            check("setup_out_valid", out_valid, 0);
            check("setup_busy", busy, 1);
            @(negedge CLK);
            check("wait_index", index, s);
            check("wait_out_valid", out_valid, 0);
            @(negedge CLK);
            check("rdout_valid", out_valid, 1);
            check("rdout_data", out_data, 8'hA0 + s);
            check("rdout_index", out_index, s);
            if (s == 0) begin
                repeat (5) begin
                    @(negedge CLK);
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, 8'hA0);
                    check("hold_out_index", out_index, 0);
                    check("hold_index", index, 0);
                end
            end
            out_ready = 1'b1;
            @(posedge CLK); #1 out_ready = 1'b0;
        end
        @(negedge CLK);
        check("sweep_end_valid", out_valid, 0);
        check("sweep_end_busy", busy, 0);

        // FIFO fills while the sweep is stalled; queued writes land afterwards
        rd_q.delete();
        start_read = 1'b1;
        @(posedge CLK); #1;
        start_read = 1'b0; in_valid = 1'b1; in_data = 8'hB0; acc = 0;
        wr_q.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            a = in_valid && in_ready;
            @(posedge CLK); #1;
            if (a) begin
                acc++;
                in_data = in_data + 8'd1;
            end
        end
        check("fill_accepted", acc, 4);
        @(negedge CLK);
        check("fill_in_ready", in_ready, 0);
        check("fill_no_write", wr_q.size(), 0);
        check("fill_still_out", out_valid, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge CLK);
        out_ready = 1'b0;
        check("fill_rd_count", rd_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check("fill_rd", (i < rd_q.size()) ? rd_q[i] : 11'h7FF, {3'(i), 8'hA0 + 8'(i)});
        check("fill_wr_count", wr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check("fill_wr", (i < wr_q.size()) ? wr_q[i] : 11'h7FF, {3'(i + 3), 8'hB0 + 8'(i)});
        check("fill_stored", stored, 7);

        // Fresh reset, then the 10-byte table
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1; use_mem = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            in_valid = 1'b1; in_data = wv[i].data;
            @(posedge CLK); #1 in_valid = 1'b0;
            found = 1'b0;
            for (int c = 0; c < 6 && !found; c++) begin
                @(negedge CLK);
                if (mode == 1'b0) found = 1'b1;
            end
            check("tbl_write_seen", found, 1);
            if (found) begin
                check("tbl_index", index, wv[i].exp_index);
                check("tbl_number", number, wv[i].data);
                @(negedge CLK);
                check("tbl_stored", stored, wv[i].exp_stored);
            end
        end

        // Read back all 8 slots through the memory model
        rd_q.delete();
        @(negedge CLK);
        out_ready = 1'b1; start_read = 1'b1;
        @(posedge CLK); #1 start_read = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge CLK);
            if (!busy) done = 1'b1;
        end
        check("sweep8_done", done, 1);
        check("sweep8_count", rd_q.size(), 8);
        for (int i = 0; i < 8; i++)
            check("sweep8_slot", (i < rd_q.size()) ? rd_q[i] : 11'h7FF, {3'(i), exp_slot[i]});
        out_ready = 1'b0;

        // Next write lands at slot 2 after the wrap
        in_valid = 1'b1; in_data = 8'h0B;
        @(posedge CLK); #1 in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge CLK);
            if (mode == 1'b0) found = 1'b1;
        end
        check("wrap_seen", found, 1);
        check("wrap_index", index, 2);

        // Reset during RD_WAIT
        @(negedge CLK);
        start_read = 1'b1;
        @(posedge CLK); #1 start_read = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("rdwait_busy", busy, 1);
        check("rdwait_out_valid", out_valid, 0);
        RST_N = 1'b0;
        @(negedge CLK);
        check("abort_out_valid", out_valid, 0);
        check("abort_stored", stored, 0);
        check("abort_busy", busy, 0);
        check("abort_mode", mode, 1);
        check("abort_in_ready", in_ready, 0);
        RST_N = 1'b1;

        // Reset during WRITE: no further write pulse, queued byte discarded
        in_valid = 1'b1; in_data = 8'h77;
        @(posedge CLK); #1 in_data = 8'h88;
        @(posedge CLK); #1 in_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge CLK);
            if (mode == 1'b0) found = 1'b1;
        end
        check("midwr_seen", found, 1);
        RST_N = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1 RST_N = 1'b1;
        wr_q.delete();
        repeat (8) @(negedge CLK);
        check("midwr_no_write", wr_q.size(), 0);
        check("midwr_stored", stored, 0);
        check("midwr_in_ready", in_ready, 1);

        check("single_cycle_writes", dbl, 0);
        check("number_zero_outside_write", num_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/em_sequencer.md
EM_SEQUENCER -- requirements
Module: em_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of input bytes buffered ahead of the write engine (power of two, 2..8).
REQ-002 CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 RST_N  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream byte available.
REQ-005 in_data  input  8  byte to store.
REQ-006 in_ready  output  1  input FIFO can accept a byte this cycle.
REQ-007 start_read  input  1  single-cycle pulse requesting a read-back sweep.
REQ-008 mode  output  1  to memory stage: 0 = write, 1 = read.
REQ-009 index  output  3  to memory stage: slot address.
REQ-010 number  output  8  to memory stage: byte being written.
REQ-011 result  input  8  from memory stage: stored byte for the presented index.
REQ-012 out_valid  output  1  read-back byte available.
REQ-013 out_data  output  8  read-back byte.
REQ-014 out_index  output  3  slot the read-back byte came from.
REQ-015 out_ready  input  1  downstream accepts the read-back byte.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 stored  output  4  number of valid slots, 0..8.

Function
REQ-018 The input transfer SHALL occur on an edge where in_valid & in_ready are both high; in_ready = FIFO not full, independent of in_valid.
REQ-019 FSM states SHALL be IDLE, WRITE, RD_SETUP, RD_WAIT, RD_OUT.
REQ-020 IDLE: mode=1. A non-empty FIFO SHALL move to WRITE. Otherwise start_read with stored>0 SHALL move to RD_SETUP. Otherwise start_read with stored=0 SHALL be ignored.
REQ-021 WRITE: for exactly one cycle, mode=0, number=FIFO head, index=wr_ptr. On that edge, pop the FIFO, set wr_ptr=wr_ptr+1 (mod 8), set stored=min(stored+1,8), and return to IDLE.
REQ-022 After wr_ptr wraps from 7 to 0, writes SHALL overwrite the oldest slots; stored saturates at 8.
REQ-023 The FIFO SHALL keep accepting bytes in every state, including during a read sweep. Writes queued during a sweep SHALL wait until the sweep ends.
REQ-024 start_read pulses SHALL be latched into a pending flag that is cleared when RD_SETUP is entered. The flag is served from IDLE only after the FIFO is empty, so all earlier writes land first.
REQ-025 The sweep SHALL visit rd_ptr = 0..stored-1 in ascending order. stored is sampled on entry to RD_SETUP.
REQ-026 For each slot, RD_SETUP SHALL present mode=1, index=rd_ptr for one cycle, then go to RD_WAIT.
REQ-027 RD_WAIT SHALL hold index for one cycle and capture result into out_data (with out_index=rd_ptr) on its edge. Total latency from index presentation to capture is 2 edges. The FSM then enters RD_OUT.
REQ-028 RD_OUT SHALL hold out_valid=1 with out_data and out_index stable until out_ready is high.
REQ-029 On acceptance in RD_OUT, the FSM SHALL go to RD_SETUP for the next slot if one remains, otherwise to IDLE; out_valid SHALL drop on the following cycle.
REQ-030 A start_read arriving during a sweep SHALL set the pending flag and start a fresh sweep after the current one completes.
REQ-031 mode SHALL be 0 only in WRITE; number SHALL be 0 outside WRITE.

Reset
REQ-032 When RST_N=0 at an edge: state=IDLE, FIFO emptied, wr_ptr=0, rd_ptr=0, stored=0, pending=0, mode=1, index=0, number=0, out_valid=0, out_data=0, out_index=0.
REQ-033 Reset asserted mid-WRITE or mid-sweep SHALL abort the operation with no further mode=0 cycle. Any bytes held in the FIFO are discarded.
REQ-034 in_ready SHALL be 0 while RST_N=0 and 1 on the first cycle after release.

Verification
REQ-035 After reset, push 0x12, 0x34, 0x56 back-to-back -> exactly three single-cycle mode=0 pulses at index 0, 1, 2 carrying number 0x12, 0x34, 0x56; stored=3.
REQ-036 Hold in_valid high with the write path blocked by a sweep -> in_ready drops after FIFO_DEPTH (4) accepted bytes; no byte is lost or duplicated.
REQ-037 Write 10 bytes 0x01..0x0A -> slots 0 and 1 hold 0x09 and 0x0A; stored saturates at 8; wr_ptr=2.
REQ-038 With stored=3 and result driven as 0xA0+index, pulse start_read -> out_index 0, 1, 2 and out_data 0xA0, 0xA1, 0xA2, each captured 2 edges after index is presented.
REQ-039 Hold out_ready=0 for 5 cycles during RD_OUT -> out_valid, out_data, and out_index stay stable, and index does not advance.
REQ-040 Assert RST_N=0 during RD_WAIT -> next cycle shows out_valid=0, stored=0, busy=0, mode=1.
